// File: rtl/fx2_pkg.sv
// Shared constants for the FX2LP slave-FIFO model: endpoint select codes and default sizing.
package fx2_pkg;
    localparam logic FIFOSEL_EP2OUT = 1'b0;
    localparam logic FIFOSEL_EP6IN  = 1'b1;

    localparam int unsigned DEFAULT_DEPTH_LOG2 = 4;
    localparam int unsigned DEFAULT_PKT_SIZE   = 8;
endpackage

// File: rtl/fx2_byte_fifo.sv
// First-word-fall-through byte FIFO with a commit pointer; only committed bytes may be popped.
module fx2_byte_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [7:0]            data_i,
    input  logic                  pop_i,
    input  logic                  commit_i,
    output logic [7:0]            data_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic [DEPTH_LOG2:0]   committed_o
);
    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0] cptr_q, cptr_d;
    logic [7:0]          mem_q [Depth];
    logic                push_ok;
    logic                pop_ok;

    assign count_o     = wptr_q - rptr_q;
    assign committed_o = cptr_q - rptr_q;
    assign data_o      = mem_q[rptr_q[DEPTH_LOG2-1:0]];

    always_comb begin
        // Count never exceeds Depth, so its MSB alone marks full.
        push_ok = push_i && !count_o[DEPTH_LOG2];
        pop_ok  = pop_i && (committed_o != '0);
        wptr_d  = wptr_q + {{DEPTH_LOG2{1'b0}}, push_ok};
        rptr_d  = rptr_q + {{DEPTH_LOG2{1'b0}}, pop_ok};
        cptr_d  = commit_i ? wptr_d : cptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q[DEPTH_LOG2-1:0]] <= data_i;
        end
    end
endmodule

// File: rtl/fx2_slave_fifo.sv
// FX2LP slave-FIFO stand-in: EP2OUT carries host bytes to the FPGA, EP6IN carries FPGA bytes
// to the host in packets committed by size or by an early packet-end strobe.
module fx2_slave_fifo
    import fx2_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int unsigned PKT_SIZE   = DEFAULT_PKT_SIZE
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       fx2FifoSel_in,
    input  logic [7:0] fx2Data_in,
    output logic [7:0] fx2Data_out,
    output logic       fx2DataDrive_out,
    input  logic       fx2Read_in,
    input  logic       fx2OE_in,
    output logic       fx2GotData_out,
    input  logic       fx2Write_in,
    output logic       fx2GotRoom_out,
    input  logic       fx2PktEnd_in,
    input  logic [7:0] hostData_in,
    input  logic       hostValid_in,
    output logic       hostReady_out,
    output logic [7:0] hostData_out,
    output logic       hostValid_out,
    input  logic       hostReady_in,
    output logic       zlp_out,
    output logic       overflow_out,
    output logic       underflow_out
);
    localparam int unsigned CntW = DEPTH_LOG2 + 1;

    logic [DEPTH_LOG2:0] ep2_count, ep2_committed;
    logic [DEPTH_LOG2:0] ep6_count, ep6_committed, ep6_unc_next;
    logic                ep2_push, ep2_pop_req;
    logic                ep6_push_req, ep6_push_ok, ep6_pop, ep6_commit, pkt_end;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                zlp_q, zlp_d;

    assign hostReady_out    = !ep2_count[DEPTH_LOG2];
    assign fx2GotData_out   = ep2_committed != '0;
    assign fx2GotRoom_out   = !ep6_count[DEPTH_LOG2];
    assign hostValid_out    = ep6_committed != '0;
    assign fx2DataDrive_out = !reset_in && (fx2FifoSel_in == FIFOSEL_EP2OUT) && !fx2OE_in;
    assign zlp_out          = zlp_q;
    assign overflow_out     = overflow_q;
    assign underflow_out    = underflow_q;

    always_comb begin
        ep2_push     = hostValid_in && hostReady_out;
        ep2_pop_req  = (fx2FifoSel_in == FIFOSEL_EP2OUT) && !fx2Read_in;
        ep6_push_req = (fx2FifoSel_in == FIFOSEL_EP6IN) && !fx2Write_in;
        ep6_push_ok  = ep6_push_req && fx2GotRoom_out;
        ep6_pop      = hostValid_out && hostReady_in;
        pkt_end      = (fx2FifoSel_in == FIFOSEL_EP6IN) && !fx2PktEnd_in;
        // Uncommitted bytes as they will stand after this edge's push.
        ep6_unc_next = ep6_count - ep6_committed + CntW'(ep6_push_ok);
        ep6_commit   = (ep6_unc_next >= CntW'(PKT_SIZE)) || (pkt_end && (ep6_unc_next != '0));
        zlp_d        = pkt_end && (ep6_unc_next == '0);
        overflow_d   = overflow_q || (ep6_push_req && !fx2GotRoom_out);
        underflow_d  = underflow_q || (ep2_pop_req && !fx2GotData_out);
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            zlp_q       <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            zlp_q       <= zlp_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fx2_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ep2out (
        .clk_i       (clk_in),
        .rst_i       (reset_in),
        .push_i      (ep2_push),
        .data_i      (hostData_in),
        .pop_i       (ep2_pop_req),
        .commit_i    (1'b1),
        .data_o      (fx2Data_out),
        .count_o     (ep2_count),
        .committed_o (ep2_committed)
    );

    fx2_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ep6in (
        .clk_i       (clk_in),
        .rst_i       (reset_in),
        .push_i      (ep6_push_req),
        .data_i      (fx2Data_in),
        .pop_i       (ep6_pop),
        .commit_i    (ep6_commit),
        .data_o      (hostData_out),
        .count_o     (ep6_count),
        .committed_o (ep6_committed)
    );
endmodule

// File: tb/tb_fx2_slave_fifo.sv
// Bench for fx2_slave_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_fx2_slave_fifo;
    localparam int DEPTH = 16;
    localparam int PKT   = 8;

    logic       clk = 1'b0;
    logic       reset_in = 1'b1;
    logic       fx2FifoSel_in = 1'b0;
    logic [7:0] fx2Data_in = 8'h00;
    logic [7:0] fx2Data_out;
    logic       fx2DataDrive_out;
    logic       fx2Read_in = 1'b1;
    logic       fx2OE_in = 1'b1;
    logic       fx2GotData_out;
    logic       fx2Write_in = 1'b1;
    logic       fx2GotRoom_out;
    logic       fx2PktEnd_in = 1'b1;
    logic [7:0] hostData_in = 8'h00;
    logic       hostValid_in = 1'b0;
    logic       hostReady_out;
    logic [7:0] hostData_out;
    logic       hostValid_out;
    logic       hostReady_in = 1'b0;
    logic       zlp_out;
    logic       overflow_out;
    logic       underflow_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] ep2_m[$];
    logic [7:0] ep6_c[$];
    logic [7:0] ep6_u[$];
    logic       m_ovf = 1'b0, m_unf = 1'b0, m_zlp = 1'b0;

    always #5 clk = ~clk;

    fx2_slave_fifo dut (
        .clk_in           (clk),
        .reset_in         (reset_in),
        .fx2FifoSel_in    (fx2FifoSel_in),
        .fx2Data_in       (fx2Data_in),
        .fx2Data_out      (fx2Data_out),
        .fx2DataDrive_out (fx2DataDrive_out),
        .fx2Read_in       (fx2Read_in),
        .fx2OE_in         (fx2OE_in),
        .fx2GotData_out   (fx2GotData_out),
        .fx2Write_in      (fx2Write_in),
        .fx2GotRoom_out   (fx2GotRoom_out),
        .fx2PktEnd_in     (fx2PktEnd_in),
        .hostData_in      (hostData_in),
        .hostValid_in     (hostValid_in),
        .hostReady_out    (hostReady_out),
        .hostData_out     (hostData_out),
        .hostValid_out    (hostValid_out),
        .hostReady_in     (hostReady_in),
        .zlp_out          (zlp_out),
        .overflow_out     (overflow_out),
        .underflow_out    (underflow_out)
    );

    // Advance the queue model by one edge using the current inputs, then clock the DUT.
    task automatic tick();
        logic [7:0] tmp;
        bit pop2, push2, pop6, push6, pe, rd, wr;
        if (reset_in) begin
            ep2_m.delete(); ep6_c.delete(); ep6_u.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_zlp = 1'b0;
        end else begin
            rd    = !fx2FifoSel_in && !fx2Read_in;
            wr    = fx2FifoSel_in && !fx2Write_in;
            push2 = hostValid_in && (ep2_m.size() < DEPTH);
            pop2  = rd && (ep2_m.size() > 0);
            if (rd && ep2_m.size() == 0) m_unf = 1'b1;
            push6 = wr && (ep6_c.size() + ep6_u.size() < DEPTH);
            if (wr && !push6) m_ovf = 1'b1;
            pop6  = (ep6_c.size() > 0) && hostReady_in;
            if (pop2) tmp = ep2_m.pop_front();
            if (push2) ep2_m.push_back(hostData_in);
            if (pop6) tmp = ep6_c.pop_front();
            if (push6) ep6_u.push_back(fx2Data_in);
            pe    = fx2FifoSel_in && !fx2PktEnd_in;
            m_zlp = pe && (ep6_u.size() == 0);
            if (ep6_u.size() >= PKT || (pe && ep6_u.size() > 0)) begin
                foreach (ep6_u[i]) ep6_c.push_back(ep6_u[i]);
                ep6_u.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fx2Read_in = 1'b1; fx2OE_in = 1'b1; fx2Write_in = 1'b1; fx2PktEnd_in = 1'b1;
        hostValid_in = 1'b0; hostReady_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_in = 1'b1; fx2FifoSel_in = 1'b0; fx2OE_in = 1'b0;
        tick(); tick();
        n_checks++;
        if ({fx2GotData_out, fx2GotRoom_out, hostReady_out, hostValid_out} !== 4'b0110) begin
            $display("FAIL reset_flags got %b want 0110",
                     {fx2GotData_out, fx2GotRoom_out, hostReady_out, hostValid_out});
        end else n_pass++;
        n_checks++;
        if ({zlp_out, overflow_out, underflow_out, fx2DataDrive_out} !== 4'b0000) begin
            $display("FAIL reset_pulses got %b want 0000",
                     {zlp_out, overflow_out, underflow_out, fx2DataDrive_out});
        end else n_pass++;
        reset_in = 1'b0; idle_inputs();
        tick();
    endtask

    task automatic test_ep2_read();
        logic [7:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        hostValid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hostData_in = exp[i];
            tick();
        end
        hostValid_in = 1'b0;
        fx2FifoSel_in = 1'b0; fx2Read_in = 1'b0; fx2OE_in = 1'b0;
        #1;
        n_checks++;
        if (fx2DataDrive_out !== 1'b1) begin
            $display("FAIL ep2_drive got %b want 1", fx2DataDrive_out);
        end else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({fx2GotData_out, fx2Data_out} !== {1'b1, exp[i]}) begin
                $display("FAIL ep2_read%0d got %b/%h want 1/%h", i, fx2GotData_out,
                         fx2Data_out, exp[i]);
            end else n_pass++;
            tick();
        end
        n_checks++;
        if (fx2GotData_out !== 1'b0) begin
            $display("FAIL ep2_empty got %b want 0", fx2GotData_out);
        end else n_pass++;
        idle_inputs();
        #1;
        n_checks++;
        if (fx2DataDrive_out !== 1'b0) begin
            $display("FAIL ep2_undrive got %b want 0", fx2DataDrive_out);
        end else n_pass++;
    endtask

    task automatic test_ep6_autocommit();
        fx2FifoSel_in = 1'b1;
        for (int i = 0; i < PKT; i++) begin
            fx2Data_in = 8'hA0 + 8'(i); fx2Write_in = 1'b0;
            tick();
            n_checks++;
            if (hostValid_out !== (i == PKT - 1)) begin
                $display("FAIL ep6_commit_after%0d got %b want %b", i + 1, hostValid_out,
                         (i == PKT - 1));
            end else n_pass++;
        end
        fx2Write_in = 1'b1; hostReady_in = 1'b1;
        for (int i = 0; i < PKT; i++) begin
            n_checks++;
            if ({hostValid_out, hostData_out} !== {1'b1, 8'hA0 + 8'(i)}) begin
                $display("FAIL ep6_drain%0d got %b/%h want 1/%h", i, hostValid_out,
                         hostData_out, 8'hA0 + 8'(i));
            end else n_pass++;
            tick();
        end
        hostReady_in = 1'b0;
        n_checks++;
        if (hostValid_out !== 1'b0) begin
            $display("FAIL ep6_drained got %b want 0", hostValid_out);
        end else n_pass++;
    endtask

    task automatic test_pktend();
        fx2FifoSel_in = 1'b1; fx2Data_in = 8'h55; fx2Write_in = 1'b0; fx2PktEnd_in = 1'b0;
        tick();
        fx2Write_in = 1'b1; fx2PktEnd_in = 1'b1;
        n_checks++;
        if ({hostValid_out, hostData_out, zlp_out} !== {1'b1, 8'h55, 1'b0}) begin
            $display("FAIL pktend_commit got %b/%h/%b want 1/55/0", hostValid_out,
                     hostData_out, zlp_out);
        end else n_pass++;
        hostReady_in = 1'b1;
        tick();
        hostReady_in = 1'b0;
        n_checks++;
        if (hostValid_out !== 1'b0) begin
            $display("FAIL pktend_drain got %b want 0", hostValid_out);
        end else n_pass++;
        fx2PktEnd_in = 1'b0;
        tick();
        fx2PktEnd_in = 1'b1;
        n_checks++;
        if ({zlp_out, hostValid_out} !== 2'b10) begin
            $display("FAIL zlp_pulse got %b want 10", {zlp_out, hostValid_out});
        end else n_pass++;
        tick();
        n_checks++;
        if (zlp_out !== 1'b0) begin
            $display("FAIL zlp_end got %b want 0", zlp_out);
        end else n_pass++;
    endtask

    task automatic test_overflow();
        fx2FifoSel_in = 1'b1; fx2Write_in = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            fx2Data_in = 8'(i);
            tick();
        end
        n_checks++;
        if ({fx2GotRoom_out, overflow_out} !== 2'b00) begin
            $display("FAIL full_room got %b want 00", {fx2GotRoom_out, overflow_out});
        end else n_pass++;
        fx2Data_in = 8'hEE;
        tick();
        fx2Write_in = 1'b1;
        n_checks++;
        if (overflow_out !== 1'b1) begin
            $display("FAIL overflow_set got %b want 1", overflow_out);
        end else n_pass++;
        hostReady_in = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if ({hostValid_out, hostData_out} !== {1'b1, 8'(i)}) begin
                $display("FAIL ovf_drain%0d got %b/%h want 1/%h", i, hostValid_out,
                         hostData_out, 8'(i));
            end else n_pass++;
            tick();
        end
        hostReady_in = 1'b0;
        n_checks++;
        if ({hostValid_out, overflow_out, fx2GotRoom_out} !== 3'b011) begin
            $display("FAIL ovf_after got %b want 011",
                     {hostValid_out, overflow_out, fx2GotRoom_out});
        end else n_pass++;
    endtask

    task automatic test_underflow();
        fx2FifoSel_in = 1'b0; fx2Read_in = 1'b0;
        tick();
        fx2Read_in = 1'b1;
        n_checks++;
        if ({underflow_out, fx2GotData_out} !== 2'b10) begin
            $display("FAIL underflow_set got %b want 10", {underflow_out, fx2GotData_out});
        end else n_pass++;
        hostValid_in = 1'b1; hostData_in = 8'h3C;
        tick();
        hostValid_in = 1'b0;
        n_checks++;
        if ({fx2GotData_out, fx2Data_out} !== {1'b1, 8'h3C}) begin
            $display("FAIL underflow_ptrs got %b/%h want 1/3c", fx2GotData_out, fx2Data_out);
        end else n_pass++;
        fx2Read_in = 1'b0;
        tick();
        fx2Read_in = 1'b1;
        n_checks++;
        if (fx2GotData_out !== 1'b0) begin
            $display("FAIL underflow_pop got %b want 0", fx2GotData_out);
        end else n_pass++;
    endtask

    task automatic test_reset_midpacket();
        reset_in = 1'b1; tick(); reset_in = 1'b0; tick();
        n_checks++;
        if ({overflow_out, underflow_out} !== 2'b00) begin
            $display("FAIL flags_cleared got %b want 00", {overflow_out, underflow_out});
        end else n_pass++;
        fx2FifoSel_in = 1'b0; fx2Read_in = 1'b0; tick(); fx2Read_in = 1'b1;
        hostValid_in = 1'b1; hostData_in = 8'h77; tick(); hostValid_in = 1'b0;
        fx2FifoSel_in = 1'b1; fx2Write_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fx2Data_in = 8'hC0 + 8'(i);
            tick();
        end
        fx2Write_in = 1'b1;
        n_checks++;
        if ({hostValid_out, underflow_out, fx2GotData_out} !== 3'b011) begin
            $display("FAIL premid got %b want 011", {hostValid_out, underflow_out, fx2GotData_out});
        end else n_pass++;
        #2;
        reset_in = 1'b1;
        #1;
        n_checks++;
        if ({hostValid_out, fx2GotRoom_out, overflow_out, underflow_out, fx2GotData_out}
                !== 5'b01000) begin
            $display("FAIL async_reset got %b want 01000", {hostValid_out, fx2GotRoom_out,
                     overflow_out, underflow_out, fx2GotData_out});
        end else n_pass++;
        tick();
        reset_in = 1'b0;
        fx2PktEnd_in = 1'b0;
        tick();
        fx2PktEnd_in = 1'b1;
        n_checks++;
        if ({zlp_out, hostValid_out} !== 2'b10) begin
            $display("FAIL discard_zlp got %b want 10", {zlp_out, hostValid_out});
        end else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic exp_drive;
        for (int c = 0; c < 600; c++) begin
            fx2FifoSel_in = 1'($urandom_range(0, 1));
            fx2Read_in    = 1'($urandom_range(0, 1));
            fx2OE_in      = 1'($urandom_range(0, 1));
            fx2Write_in   = ($urandom_range(0, 3) == 0);
            fx2PktEnd_in  = ($urandom_range(0, 9) != 0);
            fx2Data_in    = 8'($urandom);
            hostData_in   = 8'($urandom);
            hostValid_in  = 1'($urandom_range(0, 1));
            hostReady_in  = (c < 300) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            #1;
            exp_drive = !fx2FifoSel_in && !fx2OE_in;
            n_checks++;
            if (fx2GotData_out !== (ep2_m.size() > 0)) begin
                $display("FAIL rand_gotdata c%0d got %b want %b", c, fx2GotData_out,
                         (ep2_m.size() > 0));
            end else n_pass++;
            if (ep2_m.size() > 0) begin
                n_checks++;
                if (fx2Data_out !== ep2_m[0]) begin
                    $display("FAIL rand_ep2data c%0d got %h want %h", c, fx2Data_out, ep2_m[0]);
                end else n_pass++;
            end
            n_checks++;
            if (hostReady_out !== (ep2_m.size() < DEPTH)) begin
                $display("FAIL rand_hostready c%0d got %b want %b", c, hostReady_out,
                         (ep2_m.size() < DEPTH));
            end else n_pass++;
            n_checks++;
            if (hostValid_out !== (ep6_c.size() > 0)) begin
                $display("FAIL rand_hostvalid c%0d got %b want %b", c, hostValid_out,
                         (ep6_c.size() > 0));
            end else n_pass++;
            if (ep6_c.size() > 0) begin
                n_checks++;
                if (hostData_out !== ep6_c[0]) begin
                    $display("FAIL rand_ep6data c%0d got %h want %h", c, hostData_out, ep6_c[0]);
                end else n_pass++;
            end
            n_checks++;
            if (fx2GotRoom_out !== (ep6_c.size() + ep6_u.size() < DEPTH)) begin
                $display("FAIL rand_gotroom c%0d got %b want %b", c, fx2GotRoom_out,
                         (ep6_c.size() + ep6_u.size() < DEPTH));
            end else n_pass++;
            n_checks++;
            if ({zlp_out, overflow_out, underflow_out, fx2DataDrive_out}
                    !== {m_zlp, m_ovf, m_unf, exp_drive}) begin
                $display("FAIL rand_flags c%0d got %b want %b", c,
                         {zlp_out, overflow_out, underflow_out, fx2DataDrive_out},
                         {m_zlp, m_ovf, m_unf, exp_drive});
            end else n_pass++;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_ep2_read();
        test_ep6_autocommit();
        test_pktend();
        test_overflow();
        test_underflow();
        test_reset_midpacket();
        reset_in = 1'b1; tick(); reset_in = 1'b0; tick();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fx2_slave_fifo.md
FX2_SLAVE_FIFO -- requirements
Module: fx2_slave_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, meaning log2 of the byte depth of each endpoint FIFO (16 bytes).
REQ-002 Parameter PKT_SIZE, default 8, meaning the EP6IN byte count at which a packet auto-commits (1..2^DEPTH_LOG2).
REQ-003 clk_in  input  1  single clock for all logic; it stands in for the 48MHz FX2LP interface clock.
REQ-004 reset_in  input  1  asynchronous, active-high reset.
REQ-005 fx2FifoSel_in  input  1  endpoint select from the FPGA: 0 selects EP2OUT, 1 selects EP6IN.
REQ-006 fx2Data_in  input  8  byte driven by the FPGA during EP6IN writes.
REQ-007 fx2Data_out  output  8  byte presented to the FPGA from the EP2OUT head.
REQ-008 fx2DataDrive_out  output  1  high when this block drives the data bus.
REQ-009 fx2Read_in  input  1  active-low read strobe.
REQ-010 fx2OE_in  input  1  active-low output enable.
REQ-011 fx2GotData_out  output  1  active-high: EP2OUT holds at least one byte.
REQ-012 fx2Write_in  input  1  active-low write strobe.
REQ-013 fx2GotRoom_out  output  1  active-high: EP6IN has at least one free byte.
REQ-014 fx2PktEnd_in  input  1  active-low early packet commit.
REQ-015 hostData_in / hostValid_in / hostReady_out  in/in/out  8/1/1  host-to-FPGA byte stream feeding EP2OUT.
REQ-016 hostData_out / hostValid_out / hostReady_in  out/out/in  8/1/1  FPGA-to-host byte stream drained from committed EP6IN bytes.
REQ-017 zlp_out  output  1  one-cycle pulse on a zero-length packet commit.
REQ-018 overflow_out / underflow_out  output  1/1  sticky error flags.

Function
REQ-019 Both FIFOs shall be first-word-fall-through, with DEPTH_LOG2+1-bit read/write pointers; wrap-around shall be by pointer MSB, so full means 2^DEPTH_LOG2 bytes stored.
REQ-020 EP2OUT shall push hostData_in on a rising edge when hostValid_in=1 and hostReady_out=1.
REQ-021 hostReady_out shall equal "EP2OUT not full".
REQ-022 EP2OUT shall pop on a rising edge when fx2FifoSel_in=0, fx2Read_in=0 and the FIFO is non-empty.
REQ-023 fx2Data_out shall combinationally show the current EP2OUT head byte.
REQ-024 fx2DataDrive_out shall equal (fx2FifoSel_in=0 and fx2OE_in=0), and shall be forced to 0 while reset_in=1.
REQ-025 A read strobe while EP2OUT is empty shall be ignored and shall set underflow_out.
REQ-026 fx2GotData_out shall equal "EP2OUT count > 0" and fx2GotRoom_out shall equal "EP6IN count < 2^DEPTH_LOG2", both decoded from registered pointers.
REQ-027 EP6IN shall push fx2Data_in on a rising edge when fx2FifoSel_in=1, fx2Write_in=0 and the FIFO is not full.
REQ-028 A write strobe while EP6IN is full shall drop the byte and set overflow_out.
REQ-029 EP6IN shall keep a commit pointer; only bytes between the read pointer and the commit pointer shall be visible to the host (hostValid_out = committed count > 0).
REQ-030 The commit pointer shall advance to the write pointer when the uncommitted count reaches PKT_SIZE, counting any byte pushed that cycle.
REQ-031 The commit pointer shall also advance to the write pointer on an edge where fx2FifoSel_in=1 and fx2PktEnd_in=0 with a non-zero uncommitted count; a byte written on that same edge shall be included in the commit.
REQ-032 fx2PktEnd_in=0 with fx2FifoSel_in=1 and zero uncommitted bytes shall pulse zlp_out for exactly one cycle.
REQ-033 An EP6IN host pop shall occur when hostValid_out=1 and hostReady_in=1, with hostData_out showing the head byte.
REQ-034 A simultaneous push and pop on one FIFO shall both take effect, leaving the count unchanged.
REQ-035 overflow_out and underflow_out shall clear only on reset.

Reset
REQ-036 Asserting reset_in at any time, including mid-packet, shall immediately zero all pointers and discard all data, uncommitted bytes included.
REQ-037 During reset: fx2GotData_out=0, fx2GotRoom_out=1, hostReady_out=1, hostValid_out=0, zlp_out=0, overflow_out=0, underflow_out=0, fx2DataDrive_out=0.

Structure
REQ-038 Package fx2_pkg shall hold constants FIFOSEL_EP2OUT=0 and FIFOSEL_EP6IN=1 and the default DEPTH_LOG2/PKT_SIZE values.
REQ-039 One sub-module, fx2_byte_fifo (FWFT, with a commit input and a committed-count output), shall be instantiated twice; the EP2OUT instance shall tie commit permanently asserted.

Verification
REQ-040 Host pushes 0x11,0x22,0x33; FPGA reads with FifoSel=0, Read=0, OE=0 for 3 cycles -> fx2Data_out is 0x11,0x22,0x33 and fx2GotData_out falls after the third edge.
REQ-041 FPGA writes 7 bytes 0xA0..0xA6 -> hostValid_out stays 0; on the 8th byte 0xA7 -> hostValid_out=1 and the host reads 0xA0..0xA7.
REQ-042 FPGA writes 0x55 with PktEnd=0 on the same edge -> one byte is committed and the host reads 0x55; PktEnd=0 alone later -> zlp_out is high for 1 cycle.
REQ-043 16 FPGA writes without a host drain -> fx2GotRoom_out=0; a 17th write strobe -> byte dropped and overflow_out=1.
REQ-044 Read strobe on an empty EP2OUT -> underflow_out=1 and pointers unchanged.
REQ-045 Assert reset_in after 5 uncommitted EP6IN bytes -> hostValid_out=0, fx2GotRoom_out=1 and both flags 0 immediately, without waiting for a clock edge.
